// File: rtl/ne16_normquant_packer.sv
// ne16_normquant_packer: compacts the low 1/2/4 bytes of each enabled normquant lane into strobed OUT_BYTES words.
// Optional macro NE16_PACKER_SATURATE_EN clamps each lane to the selected output width before byte selection.
module ne16_normquant_packer #(
    parameter int unsigned NMULT     = 4,
    parameter int unsigned OUT_BYTES = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [NMULT*32-1:0]    in_data_i,
    input  logic [NMULT-1:0]       in_mask_i,
    input  logic                   in_last_i,
    input  logic [1:0]             quant_mode_i,
    input  logic                   quant_signed_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [OUT_BYTES*8-1:0] out_data_o,
    output logic [OUT_BYTES-1:0]   out_strb_o,
    output logic                   out_last_o,
    output logic                   busy_o
);
    localparam int unsigned IN_BYTES  = NMULT * 4;
    localparam int unsigned BUF_BYTES = 2 * OUT_BYTES;
    localparam int unsigned CNT_W     = $clog2(BUF_BYTES + 1);
    localparam int unsigned NIN_W     = $clog2(IN_BYTES + 1);
    localparam int unsigned PIDX_W    = $clog2(IN_BYTES);
    localparam logic [CNT_W-1:0] OUT_CNT   = CNT_W'(OUT_BYTES);
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(BUF_BYTES - IN_BYTES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FLUSH = 2'd2
    } state_e;

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic [BUF_BYTES-1:0][7:0] buf_q, buf_d;
    logic                      in_ready_q, in_ready_d;
    logic                      out_valid_q, out_valid_d;
    logic [OUT_BYTES-1:0][7:0] out_data_q, out_data_d;
    logic [OUT_BYTES-1:0]      out_strb_q, out_strb_d;
    logic                      out_last_q, out_last_d;
    logic                      busy_q, busy_d;

    logic [3:0]       byte_en;
    logic [7:0]       in_bytes [IN_BYTES];
    logic [NIN_W-1:0] n_in;
    logic [31:0]      lane;
    logic [CNT_W-1:0] off;
    logic             in_fire;
    logic             out_fire;
    logic             hold;

`ifdef NE16_PACKER_SATURATE_EN
    // Clamp a lane to the 8b/16b range; 32b passes through untouched.
    function automatic logic [31:0] saturate(input logic [31:0] v, input logic [1:0] mode,
                                             input logic sgn);
        logic signed [31:0] s;
        logic signed [31:0] lo;
        logic signed [31:0] hi;
        s = signed'(v);
        if (mode == 2'd1) begin
            lo = sgn ? -32'sd32768 : 32'sd0;
            hi = sgn ? 32'sd32767 : 32'sd65535;
        end else begin
            lo = sgn ? -32'sd128 : 32'sd0;
            hi = sgn ? 32'sd127 : 32'sd255;
        end
        if (mode == 2'd2) return v;
        if (s < lo) return unsigned'(lo);
        if (s > hi) return unsigned'(hi);
        return v;
    endfunction
`else
    logic unused_signed;
    assign unused_signed = quant_signed_i;
`endif

    assign in_fire  = in_valid_i & in_ready_q;
    assign out_fire = out_valid_q & out_ready_i;
    assign hold     = out_valid_q & ~out_ready_i;

    always_comb begin
        case (quant_mode_i)
            2'd1:    byte_en = 4'b0011;
            2'd2:    byte_en = 4'b1111;
            default: byte_en = 4'b0001;
        endcase
    end

    // Compact enabled lanes, ascending lane order, little-endian bytes within a lane.
    always_comb begin
        n_in = '0;
        lane = '0;
        for (int i = 0; i < int'(IN_BYTES); i++) in_bytes[i] = 8'h00;
        for (int k = 0; k < int'(NMULT); k++) begin
`ifdef NE16_PACKER_SATURATE_EN
            lane = saturate(in_data_i[32*k +: 32], quant_mode_i, quant_signed_i);
`else
            lane = in_data_i[32*k +: 32];
`endif
            for (int b = 0; b < 4; b++) begin
                if (in_mask_i[k] && byte_en[b]) begin
                    in_bytes[n_in[PIDX_W-1:0]] = lane[8*b +: 8];
                    n_in = n_in + NIN_W'(1);
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        buf_d       = buf_q;
        off         = '0;
        in_ready_d  = 1'b0;
        busy_d      = 1'b0;
        out_valid_d = 1'b0;
        out_data_d  = '0;
        out_strb_d  = '0;
        out_last_d  = 1'b0;

        if (out_fire) begin
            if (state_q == FLUSH && out_last_q) begin
                state_d = IDLE;
                count_d = '0;
            end else begin
                buf_d   = buf_q >> (OUT_BYTES * 8);
                count_d = count_q - OUT_CNT;
            end
        end

        // New bytes land after any shift performed in the same cycle.
        if (in_fire) begin
            for (int i = 0; i < int'(BUF_BYTES); i++) begin
                off = CNT_W'(i) - count_d;
                if (CNT_W'(i) >= count_d && off < CNT_W'(n_in)) begin
                    buf_d[i] = in_bytes[off[PIDX_W-1:0]];
                end
            end
            count_d = count_d + CNT_W'(n_in);
            if (in_last_i) begin
                state_d = FLUSH;
            end else if (state_q == IDLE) begin
                state_d = ACCUM;
            end
        end

        in_ready_d = (state_d != FLUSH) && (count_d <= READY_MAX);
        busy_d     = (state_d != IDLE);

        // A stalled word is frozen; otherwise present the oldest bytes of the next buffer.
        if (hold) begin
            out_valid_d = out_valid_q;
            out_data_d  = out_data_q;
            out_strb_d  = out_strb_q;
            out_last_d  = out_last_q;
        end else begin
            out_valid_d = (count_d >= OUT_CNT) || (state_d == FLUSH);
            out_last_d  = (state_d == FLUSH) && (count_d <= OUT_CNT);
            for (int i = 0; i < int'(OUT_BYTES); i++) begin
                if (out_valid_d && CNT_W'(i) < count_d) begin
                    out_strb_d[i] = 1'b1;
                    out_data_d[i] = buf_d[i];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q     <= IDLE;
            count_q     <= '0;
            buf_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_strb_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            buf_q       <= buf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_strb_q  <= out_strb_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_strb_o  = out_strb_q;
    assign out_last_o  = out_last_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_ne16_normquant_packer.sv
// Directed self-checking bench for ne16_normquant_packer (default NMULT=4, OUT_BYTES=16).
module tb_ne16_normquant_packer;
    localparam int unsigned NMULT     = 4;
    localparam int unsigned OUT_BYTES = 16;

    typedef struct packed {
        logic [OUT_BYTES*8-1:0] data;
        logic [OUT_BYTES-1:0]   strb;
        logic                   last;
    } word_t;

    logic                   clk_i = 1'b0;
    logic                   rst_i;
    logic                   clear_i;
    logic                   in_valid_i;
    logic                   in_ready_o;
    logic [NMULT*32-1:0]    in_data_i;
    logic [NMULT-1:0]       in_mask_i;
    logic                   in_last_i;
    logic [1:0]             quant_mode_i;
    logic                   quant_signed_i;
    logic                   out_valid_o;
    logic                   out_ready_i;
    logic [OUT_BYTES*8-1:0] out_data_o;
    logic [OUT_BYTES-1:0]   out_strb_o;
    logic                   out_last_o;
    logic                   busy_o;

    int    n_cmp   = 0;
    int    n_mis   = 0;
    int    rdy_low = 0;
    word_t words[$];

    always #5 clk_i = ~clk_i;

    ne16_normquant_packer #(.NMULT(NMULT), .OUT_BYTES(OUT_BYTES)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
        .in_mask_i(in_mask_i), .in_last_i(in_last_i), .quant_mode_i(quant_mode_i),
        .quant_signed_i(quant_signed_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_data_o(out_data_o), .out_strb_o(out_strb_o), .out_last_o(out_last_o),
        .busy_o(busy_o)
    );

    // Record transferred words, input stalls, and buffer occupancy bound.
    always @(negedge clk_i) begin
        word_t w;
        if (!rst_i && !clear_i) begin
            if (out_valid_o && out_ready_i) begin
                w.data = out_data_o;
                w.strb = out_strb_o;
                w.last = out_last_o;
                words.push_back(w);
            end
            if (in_valid_i && !in_ready_o) rdy_low++;
            n_cmp++;
            if (int'(dut.count_q) > int'(2 * OUT_BYTES)) begin
                n_mis++;
                $display("FAIL overflow count=%0d max=%0d", dut.count_q, 2 * OUT_BYTES);
            end
        end
    end

    task automatic send(input logic [NMULT*32-1:0] d, input logic [NMULT-1:0] m, input logic l);
        int c = 0;
        in_data_i  = d;
        in_mask_i  = m;
        in_last_i  = l;
        in_valid_i = 1'b1;
        while (!in_ready_o && c < 200) begin
            @(posedge clk_i); #1;
            c++;
        end
        n_cmp++;
        if (!in_ready_o) begin
            n_mis++;
            $display("FAIL send_timeout in_ready=%b want 1", in_ready_o);
        end
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
    endtask

    task automatic wait_words(input int n);
        int c = 0;
        while (words.size() < n && c < 200) begin
            @(posedge clk_i); #1;
            c++;
        end
        n_cmp++;
        if (words.size() < n) begin
            n_mis++;
            $display("FAIL wait_words got %0d words want %0d", words.size(), n);
        end
    endtask

    task automatic test_reset;
        rst_i = 1'b1; clear_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0; in_mask_i = '0;
        in_last_i = 1'b0; quant_mode_i = 2'd0; quant_signed_i = 1'b0; out_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        n_cmp++; if (out_valid_o !== 1'b0) begin n_mis++; $display("FAIL rst_valid got %b want 0", out_valid_o); end
        n_cmp++; if (out_strb_o !== 16'h0) begin n_mis++; $display("FAIL rst_strb got %h want 0", out_strb_o); end
        n_cmp++; if (out_last_o !== 1'b0) begin n_mis++; $display("FAIL rst_last got %b want 0", out_last_o); end
        n_cmp++; if (out_data_o !== 128'h0) begin n_mis++; $display("FAIL rst_data got %h want 0", out_data_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_mis++; $display("FAIL rst_busy got %b want 0", busy_o); end
        n_cmp++; if (in_ready_o !== 1'b1) begin n_mis++; $display("FAIL rst_ready got %b want 1", in_ready_o); end
    endtask

    task automatic test_8b_full_word;
        logic [NMULT*32-1:0] d;
        quant_mode_i = 2'd0; out_ready_i = 1'b1; words.delete();
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 4; k++) d[32*k +: 32] = 32'(4 * b + k);
            send(d, 4'hF, b == 3);
            if (b == 2) begin
                n_cmp++; if (out_valid_o !== 1'b0) begin n_mis++; $display("FAIL b8_early_valid got %b want 0", out_valid_o); end
            end
        end
        n_cmp++; if (out_valid_o !== 1'b1) begin n_mis++; $display("FAIL b8_latency got %b want 1", out_valid_o); end
        n_cmp++; if (in_ready_o !== 1'b0) begin n_mis++; $display("FAIL b8_flush_ready got %b want 0", in_ready_o); end
        wait_words(1);
        repeat (4) @(posedge clk_i);
        #1;
        n_cmp++; if (words.size() != 1) begin n_mis++; $display("FAIL b8_count got %0d want 1", words.size()); end
        if (words.size() >= 1) begin
            n_cmp++; if (words[0].data !== 128'h0F0E0D0C_0B0A0908_07060504_03020100) begin n_mis++; $display("FAIL b8_data got %h want 0f0e..0100", words[0].data); end
            n_cmp++; if (words[0].strb !== 16'hFFFF) begin n_mis++; $display("FAIL b8_strb got %h want ffff", words[0].strb); end
            n_cmp++; if (words[0].last !== 1'b1) begin n_mis++; $display("FAIL b8_last got %b want 1", words[0].last); end
        end
        n_cmp++; if (busy_o !== 1'b0) begin n_mis++; $display("FAIL b8_busy got %b want 0", busy_o); end
    endtask

    task automatic test_back_to_back;
        logic [NMULT*32-1:0] d;
        quant_mode_i = 2'd2; out_ready_i = 1'b1; words.delete(); rdy_low = 0;
        for (int b = 0; b < 6; b++) begin
            for (int k = 0; k < 4; k++) d[32*k +: 32] = 32'hC0DE_0000 | 32'(16 * b + k);
            send(d, 4'hF, b == 5);
        end
        wait_words(6);
        repeat (4) @(posedge clk_i);
        #1;
        n_cmp++; if (rdy_low != 0) begin n_mis++; $display("FAIL b2b_ready_stalls got %0d want 0", rdy_low); end
        n_cmp++; if (words.size() != 6) begin n_mis++; $display("FAIL b2b_count got %0d want 6", words.size()); end
        for (int b = 0; b < 6 && b < words.size(); b++) begin
            for (int k = 0; k < 4; k++) d[32*k +: 32] = 32'hC0DE_0000 | 32'(16 * b + k);
            n_cmp++; if (words[b].data !== d) begin n_mis++; $display("FAIL b2b_data[%0d] got %h want %h", b, words[b].data, d); end
            n_cmp++; if (words[b].strb !== 16'hFFFF) begin n_mis++; $display("FAIL b2b_strb[%0d] got %h want ffff", b, words[b].strb); end
            n_cmp++; if (words[b].last !== (b == 5)) begin n_mis++; $display("FAIL b2b_last[%0d] got %b want %b", b, words[b].last, b == 5); end
        end
    endtask

    task automatic test_16b_partial;
        quant_mode_i = 2'd1; out_ready_i = 1'b1; words.delete();
        send({32'h6666_6666, 32'hBBBB_0302, 32'h5555_5555, 32'hAAAA_0100}, 4'b0101, 1'b0);
        send({32'h7777_7777, 32'hCCCC_0706, 32'h8888_8888, 32'hDDDD_0504}, 4'b0101, 1'b0);
        send({32'h9999_9999, 32'hEEEE_0B0A, 32'h1234_5678, 32'hFFFF_0908}, 4'b0101, 1'b1);
        wait_words(1);
        repeat (3) @(posedge clk_i);
        #1;
        n_cmp++; if (words.size() != 1) begin n_mis++; $display("FAIL b16_count got %0d want 1", words.size()); end
        if (words.size() >= 1) begin
            n_cmp++; if (words[0].data !== 128'h0000_0000_0B0A_0908_0706_0504_0302_0100) begin n_mis++; $display("FAIL b16_data got %h want 0b0a..0100", words[0].data); end
            n_cmp++; if (words[0].strb !== 16'h0FFF) begin n_mis++; $display("FAIL b16_strb got %h want 0fff", words[0].strb); end
            n_cmp++; if (words[0].last !== 1'b1) begin n_mis++; $display("FAIL b16_last got %b want 1", words[0].last); end
        end
    endtask

    task automatic test_empty_last;
        quant_mode_i = 2'd0; out_ready_i = 1'b1; words.delete();
        send(128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555, 4'h0, 1'b1);
        n_cmp++; if (out_valid_o !== 1'b1 || out_last_o !== 1'b1 || out_strb_o !== 16'h0) begin
            n_mis++; $display("FAIL empty_word got v=%b l=%b s=%h want v=1 l=1 s=0000", out_valid_o, out_last_o, out_strb_o);
        end
        n_cmp++; if (busy_o !== 1'b1) begin n_mis++; $display("FAIL empty_busy_hi got %b want 1", busy_o); end
        wait_words(1);
        @(posedge clk_i); #1;
        n_cmp++; if (busy_o !== 1'b0) begin n_mis++; $display("FAIL empty_busy_lo got %b want 0", busy_o); end
        n_cmp++; if (out_valid_o !== 1'b0) begin n_mis++; $display("FAIL empty_valid_lo got %b want 0", out_valid_o); end
        n_cmp++; if (words.size() != 1) begin n_mis++; $display("FAIL empty_count got %0d want 1", words.size()); end
    endtask

    task automatic test_stall_clear;
        logic [127:0] da;
        logic [127:0] db;
        logic [127:0] dc;
        da = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
        db = 128'h1F1E1D1C_1B1A1918_17161514_13121110;
        dc = 128'h2F2E2D2C_2B2A2928_27262524_23222120;
        quant_mode_i = 2'd2; out_ready_i = 1'b0; words.delete();
        send(da, 4'hF, 1'b0);
        n_cmp++; if (in_ready_o !== 1'b1) begin n_mis++; $display("FAIL stall_ready16 got %b want 1", in_ready_o); end
        send(db, 4'hF, 1'b0);
        n_cmp++; if (in_ready_o !== 1'b0) begin n_mis++; $display("FAIL stall_ready32 got %b want 0", in_ready_o); end
        n_cmp++; if (out_valid_o !== 1'b1 || out_data_o !== da) begin n_mis++; $display("FAIL stall_word got v=%b d=%h want v=1 d=%h", out_valid_o, out_data_o, da); end
        repeat (5) @(posedge clk_i);
        #1;
        n_cmp++; if (out_valid_o !== 1'b1 || out_data_o !== da || out_strb_o !== 16'hFFFF) begin
            n_mis++; $display("FAIL stall_hold got v=%b d=%h s=%h want v=1 d=%h s=ffff", out_valid_o, out_data_o, out_strb_o, da);
        end
        out_ready_i = 1'b1;
        send(dc, 4'hF, 1'b1);
        wait_words(3);
        repeat (3) @(posedge clk_i);
        #1;
        n_cmp++; if (words.size() != 3) begin n_mis++; $display("FAIL stall_count got %0d want 3", words.size()); end
        if (words.size() == 3) begin
            n_cmp++; if (words[0].data !== da || words[0].last !== 1'b0) begin n_mis++; $display("FAIL stall_w0 got %h/%b want %h/0", words[0].data, words[0].last, da); end
            n_cmp++; if (words[1].data !== db || words[1].last !== 1'b0) begin n_mis++; $display("FAIL stall_w1 got %h/%b want %h/0", words[1].data, words[1].last, db); end
            n_cmp++; if (words[2].data !== dc || words[2].last !== 1'b1) begin n_mis++; $display("FAIL stall_w2 got %h/%b want %h/1", words[2].data, words[2].last, dc); end
        end
        out_ready_i = 1'b0; words.delete();
        send(da, 4'hF, 1'b0);
        send(db, 4'hF, 1'b0);
        clear_i = 1'b1;
        @(posedge clk_i); #1;
        clear_i = 1'b0;
        n_cmp++; if (out_valid_o !== 1'b0 || out_strb_o !== 16'h0) begin n_mis++; $display("FAIL clear_out got v=%b s=%h want v=0 s=0000", out_valid_o, out_strb_o); end
        n_cmp++; if (busy_o !== 1'b0 || in_ready_o !== 1'b1) begin n_mis++; $display("FAIL clear_ctrl got busy=%b rdy=%b want busy=0 rdy=1", busy_o, in_ready_o); end
        quant_mode_i = 2'd0; out_ready_i = 1'b1;
        send({32'h0000_0044, 32'h0000_0033, 32'h0000_0022, 32'h0000_0011}, 4'hF, 1'b1);
        wait_words(1);
        repeat (3) @(posedge clk_i);
        #1;
        n_cmp++; if (words.size() != 1) begin n_mis++; $display("FAIL clear_recover_count got %0d want 1", words.size()); end
        if (words.size() >= 1) begin
            n_cmp++; if (words[0].data !== 128'h4433_2211 || words[0].strb !== 16'h000F || words[0].last !== 1'b1) begin
                n_mis++; $display("FAIL clear_recover got %h/%h/%b want 44332211/000f/1", words[0].data, words[0].strb, words[0].last);
            end
        end
    endtask

`ifdef NE16_PACKER_SATURATE_EN
    task automatic test_saturate;
        logic [127:0] d;
        d = {32'hFFFF_FFFF, 32'h0000_007F, 32'hFFFF_FED4, 32'h0000_012C};
        quant_mode_i = 2'd0; out_ready_i = 1'b1;
        quant_signed_i = 1'b1; words.delete();
        send(d, 4'hF, 1'b1);
        wait_words(1);
        if (words.size() >= 1) begin
            n_cmp++; if (words[0].data !== 128'hFF7F_807F || words[0].strb !== 16'h000F) begin n_mis++; $display("FAIL sat_signed got %h/%h want ff7f807f/000f", words[0].data, words[0].strb); end
        end
        repeat (2) @(posedge clk_i);
        #1;
        quant_signed_i = 1'b0; words.delete();
        send(d, 4'hF, 1'b1);
        wait_words(1);
        if (words.size() >= 1) begin
            n_cmp++; if (words[0].data !== 128'h007F_00FF || words[0].strb !== 16'h000F) begin n_mis++; $display("FAIL sat_unsigned got %h/%h want 007f00ff/000f", words[0].data, words[0].strb); end
        end
        repeat (2) @(posedge clk_i);
        #1;
    endtask
`else
    task automatic test_truncate;
        quant_mode_i = 2'd3; quant_signed_i = 1'b1; out_ready_i = 1'b1; words.delete();
        send({32'hFFFF_FFFF, 32'h0000_007F, 32'hFFFF_FED4, 32'h0000_012C}, 4'hF, 1'b1);
        wait_words(1);
        if (words.size() >= 1) begin
            n_cmp++; if (words[0].data !== 128'hFF7F_D42C || words[0].strb !== 16'h000F) begin n_mis++; $display("FAIL trunc_mode3 got %h/%h want ff7fd42c/000f", words[0].data, words[0].strb); end
        end
        repeat (2) @(posedge clk_i);
        #1;
    endtask
`endif

    initial begin
        test_reset();
        test_8b_full_word();
        test_back_to_back();
        test_16b_partial();
        test_empty_last();
        test_stall_clear();
`ifdef NE16_PACKER_SATURATE_EN
        test_saturate();
`else
        test_truncate();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
